// File: rtl/vram_writer.sv
// Host write path into the shared 256K x 16 video SRAM: command FIFO, bus request,
// and a fixed SETUP/STROBE/HOLD write strobe per word with fill support.
`timescale 1ns/1ps
module vram_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 10
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               cmdValid,
    output logic               cmdReady,
    input  logic [17:0]        cmdAddr,
    input  logic [15:0]        cmdData,
    input  logic [1:0]         cmdBe,
    input  logic [COUNT_W-1:0] cmdCount,
    output logic               busReq,
    input  logic               busGrant,
    output logic               busy,
    output logic [17:0]        ram_addr,
    output logic [15:0]        ram_dout,
    output logic               ram_ce,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               ram_lb,
    output logic               ram_hb
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 18 + 16 + 2 + COUNT_W;

    typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, nxt_ptr;
    logic [CNT_W-1:0]     count_q;
    logic                 rdy_q;
    logic                 push, pop, full;
    logic [17:0]          addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic [1:0]           be_q, be_d;
    logic [COUNT_W-1:0]   rem_q, rem_d;
    logic [17:0]          ram_addr_q;
    logic [15:0]          ram_dout_q;

    // rdy_q keeps cmdReady low until the first edge after reset release
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmdReady = rdy_q & ~full;
    assign push     = cmdValid & cmdReady;
    assign nxt_ptr  = rd_ptr_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {cmdAddr, cmdData, cmdBe, cmdCount};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdy_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= nxt_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The head entry stays in the FIFO until its last word completes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    {addr_d, data_d, be_d, rem_d} = mem_q[rd_ptr_q];
                    state_d = REQ;
                end
            end
            REQ:    if (busGrant) state_d = SETUP;
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                if (rem_q != '0) begin
                    addr_d  = addr_q + 18'd1;
                    rem_d   = rem_q - COUNT_W'(1);
                    state_d = busGrant ? SETUP : REQ;
                end else begin
                    pop = 1'b1;
                    if (count_q > CNT_W'(1) && busGrant) begin
                        {addr_d, data_d, be_d, rem_d} = mem_q[nxt_ptr];
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            rem_q      <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            rem_q   <= rem_d;
            // SRAM address/data only move on entry to SETUP, so they hold while released
            if (state_d == SETUP) begin
                ram_addr_q <= addr_d;
                ram_dout_q <= data_d;
            end
        end
    end

    assign ram_ce   = (state_q == SETUP) | (state_q == STROBE) | (state_q == HOLD);
    assign ram_we   = (state_q == STROBE);
    assign ram_oe   = 1'b0;
    assign ram_lb   = ram_ce & be_q[0];
    assign ram_hb   = ram_ce & be_q[1];
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign busReq   = (state_q != IDLE);
    assign busy     = (count_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: single write, wrapping fill, back-pressure,
// grant withdrawal, byte enables and reset in the middle of a word.
`timescale 1ns/1ps
module tb_vram_writer;
    localparam int FIFO_DEPTH = 4;
    localparam int COUNT_W    = 10;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               cmdValid = 1'b0;
    logic               busGrant = 1'b0;
    logic [17:0]        cmdAddr = '0;
    logic [15:0]        cmdData = '0;
    logic [1:0]         cmdBe = '0;
    logic [COUNT_W-1:0] cmdCount = '0;
    logic               cmdReady, busReq, busy;
    logic [17:0]        ram_addr;
    logic [15:0]        ram_dout;
    logic               ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

    int n_chk = 0;
    int n_err = 0;

    logic [17:0] wa [$];
    logic [15:0] wd [$];
    logic [1:0]  wbe [$];
    int          runs [$];
    int          ce_cnt = 0;
    int          we_cnt = 0;
    int          run = 0;

    always #5 clk = ~clk;

    vram_writer #(.FIFO_DEPTH(FIFO_DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdBe(cmdBe), .cmdCount(cmdCount),
        .busReq(busReq), .busGrant(busGrant), .busy(busy),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_ce(ram_ce), .ram_oe(ram_oe),
        .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
    );

    // bus monitor: logs every strobed word and the length of each ce run
    always @(negedge clk) begin
        if (ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_dout);
            wbe.push_back({ram_hb, ram_lb});
            we_cnt++;
        end
        if (ram_ce) begin
            ce_cnt++;
            run++;
        end else if (run != 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                        input logic [COUNT_W-1:0] c);
        cmdAddr = a; cmdData = d; cmdBe = be; cmdCount = c; cmdValid = 1'b1;
        step();
        cmdValid = 1'b0;
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (!ram_we && n < 50) begin step(); n++; end
        chk(tag, ram_we, 1);
    endtask

    task automatic wait_ce(input string tag);
        int n = 0;
        while (!ram_ce && n < 50) begin step(); n++; end
        chk(tag, ram_ce, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin step(); n++; end
        chk(tag, busy, 0);
        step();
    endtask

    initial begin
        int bw, bce, bwe, br;

        // reset state
        #12;
        chk("rst_busReq", busReq, 0);
        chk("rst_ce", ram_ce, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_lbhb", {ram_hb, ram_lb}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_dout", ram_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmdReady, 0);
        #1 resetN = 1'b1;
        step();
        chk("post_rst_ready", cmdReady, 1);

        // single write with grant always present
        busGrant = 1'b1;
        push(18'h02000, 16'hA5C3, 2'b11, '0);
        chk("s_busy", busy, 1);
        chk("s_idle_req", busReq, 0);
        step();
        chk("s_req", busReq, 1);
        chk("s_req_ce", ram_ce, 0);
        step();
        chk("s_setup_ce", ram_ce, 1);
        chk("s_setup_we", ram_we, 0);
        chk("s_addr", ram_addr, 18'h02000);
        chk("s_dout", ram_dout, 16'hA5C3);
        step();
        chk("s_strobe_we", ram_we, 1);
        chk("s_strobe_ce", ram_ce, 1);
        step();
        chk("s_hold_ce", ram_ce, 1);
        chk("s_hold_we", ram_we, 0);
        step();
        chk("s_end_req", busReq, 0);
        chk("s_end_ce", ram_ce, 0);
        chk("s_end_busy", busy, 0);
        step();

        // fill across the top of the address space
        bw = wa.size(); bce = ce_cnt; bwe = we_cnt; br = runs.size();
        push(18'h3FFFE, 16'h1234, 2'b11, 10'd3);
        wait_idle("f_idle");
        chk("f_nwr", wa.size() - bw, 4);
        if (wa.size() >= bw + 4) begin
            chk("f_a0", wa[bw],   18'h3FFFE);
            chk("f_a1", wa[bw+1], 18'h3FFFF);
            chk("f_a2", wa[bw+2], 18'h00000);
            chk("f_a3", wa[bw+3], 18'h00001);
            chk("f_d3", wd[bw+3], 16'h1234);
        end
        chk("f_ce", ce_cnt - bce, 12);
        chk("f_we", we_cnt - bwe, 4);
        chk("f_nrun", runs.size() - br, 1);
        if (runs.size() > br) chk("f_run", runs[br], 12);

        // back-pressure: five commands, no grant
        busGrant = 1'b0;
        bw = wa.size(); br = runs.size();
        for (int k = 0; k < 4; k++) begin
            cmdAddr = 18'h01000 + 18'(k * 16); cmdData = 16'hC000 + 16'(k);
            cmdBe = 2'b11; cmdCount = '0; cmdValid = 1'b1;
            chk("bp_ready", cmdReady, 1);
            step();
        end
        chk("bp_full", cmdReady, 0);
        cmdAddr = 18'h01040; cmdData = 16'hC004;
        step(); step(); step();
        chk("bp_held", cmdReady, 0);
        chk("bp_req", busReq, 1);
        chk("bp_noce", ram_ce, 0);
        chk("bp_busy", busy, 1);
        busGrant = 1'b1;
        begin
            int n = 0;
            while (!cmdReady && n < 20) begin step(); n++; end
        end
        chk("bp_reopen", cmdReady, 1);
        step();
        cmdValid = 1'b0;
        wait_idle("bp_idle");
        chk("bp_nwr", wa.size() - bw, 5);
        if (wa.size() >= bw + 5)
            for (int i = 0; i < 5; i++) begin
                chk("bp_addr", wa[bw+i], 18'h01000 + 18'(i * 16));
                chk("bp_data", wd[bw+i], 16'hC000 + 16'(i));
            end
        chk("bp_nrun", runs.size() - br, 1);
        if (runs.size() > br) chk("bp_run", runs[br], 15);

        // grant withdrawn during the first strobe of a 2-word fill
        bw = wa.size();
        push(18'h00100, 16'hBEEF, 2'b11, 10'd1);
        wait_we("g_we");
        busGrant = 1'b0;
        step();
        chk("g_hold_ce", ram_ce, 1);
        chk("g_hold_we", ram_we, 0);
        step();
        chk("g_req_ce", ram_ce, 0);
        chk("g_req", busReq, 1);
        chk("g_addr_held", ram_addr, 18'h00100);
        bce = ce_cnt;
        for (int i = 0; i < 6; i++) step();
        chk("g_wait_ce", ce_cnt - bce, 0);
        busGrant = 1'b1;
        step();
        chk("g_regrant_ce", ram_ce, 1);
        chk("g_regrant_addr", ram_addr, 18'h00101);
        wait_idle("g_idle");
        chk("g_nwr", wa.size() - bw, 2);
        if (wa.size() >= bw + 2) begin
            chk("g_a0", wa[bw], 18'h00100);
            chk("g_a1", wa[bw+1], 18'h00101);
            chk("g_d1", wd[bw+1], 16'hBEEF);
        end

        // byte enables
        push(18'h00055, 16'h00FF, 2'b01, '0);
        wait_ce("b1_ce");
        chk("b1_setup", {ram_hb, ram_lb, ram_we}, 3'b010);
        step();
        chk("b1_strobe", {ram_hb, ram_lb, ram_we}, 3'b011);
        step();
        chk("b1_hold", {ram_hb, ram_lb, ram_we, ram_ce}, 4'b0101);
        step();
        chk("b1_end", {ram_hb, ram_lb, ram_ce}, 3'b000);
        push(18'h00056, 16'h1111, 2'b00, '0);
        wait_ce("b0_ce");
        chk("b0_setup", {ram_hb, ram_lb, ram_we}, 3'b000);
        step();
        chk("b0_strobe", {ram_hb, ram_lb, ram_we, ram_ce}, 4'b0011);
        step();
        chk("b0_hold", {ram_hb, ram_lb, ram_we, ram_ce}, 4'b0001);
        step();
        chk("b0_end", ram_ce, 0);
        step();

        // reset during a strobe with a second command queued
        push(18'h2A000, 16'h7777, 2'b11, 10'd5);
        push(18'h2B000, 16'h8888, 2'b11, 10'd0);
        wait_we("r_we");
        #2 resetN = 1'b0;
        #1;
        chk("r_we0", ram_we, 0);
        chk("r_ce0", ram_ce, 0);
        chk("r_req0", busReq, 0);
        chk("r_ready0", cmdReady, 0);
        @(posedge clk);
        #3 resetN = 1'b1;
        step();
        chk("r_busy", busy, 0);
        chk("r_ready", cmdReady, 1);
        chk("r_addr", ram_addr, 0);
        bce = ce_cnt;
        for (int i = 0; i < 5; i++) step();
        chk("r_quiet", ce_cnt - bce, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
